bcrypt_encode: RTL
==================

BCRYPT_ENCODE -- requirements
Module: bcrypt_encode

Interface
REQ-001 SHALL provide parameter VERSION_CHAR, default 8'h62 ('b'), minor-version character emitted at header position 2.
REQ-002 SHALL provide parameter COST_MIN, default 4, smallest legal cost value.
REQ-003 clk  input  1  single clock; all logic on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-low.
REQ-005 enc_en  input  1  start request; cost/salt/ctext are valid in the same cycle.
REQ-006 cost  input  5  bcrypt cost factor.
REQ-007 salt  input  128  raw salt, bit 127 first.
REQ-008 ctext  input  184  raw ciphertext, bit 183 first.
REQ-009 enc_busy  output  1  encoding in progress.
REQ-010 enc_done  output  1  one-cycle completion pulse.
REQ-011 err_cost  output  1  cost below COST_MIN; valid with enc_done.
REQ-012 out_valid  output  1  out_byte holds a valid character.
REQ-013 out_ready  input  1  consumer accepts out_byte.
REQ-014 out_byte  output  8  ASCII character.
REQ-015 out_last  output  1  marks the final (60th) character.

Function
REQ-016 SHALL emit the 60-character string "$2" VERSION_CHAR "$" DD "$" S[22] H[31], with one character per accepted transfer.
REQ-017 DD SHALL be the two-digit decimal of cost, with a leading '0' below 10. Example: cost 5 -> "05", cost 31 -> "31".
REQ-018 S SHALL be salt zero-padded to 132 bits, split MSB-first into 22 6-bit groups.
REQ-019 H SHALL be ctext zero-padded to 186 bits, split MSB-first into 31 6-bit groups.
REQ-020 Each 6-bit group SHALL map through the alphabet "./A-Za-z0-9":
  - 0-1 -> '.', '/'
  - 2-27 -> 'A'-'Z'
  - 28-53 -> 'a'-'z'
  - 54-63 -> '0'-'9'
REQ-021 The FSM SHALL have states IDLE, HDR (index 0-6), SALT (7-28), HASH (29-59), DONE.
  - The index counter is 6 bits, 0..59, and advances only on out_valid && out_ready.
REQ-022 In IDLE, enc_en=1 SHALL capture all inputs into internal shift registers and enter HDR. out_valid SHALL go high the next cycle with '$'.
REQ-023 Shift registers SHALL shift left by 6 on each accepted SALT or HASH character.
REQ-024 While out_valid=1 and out_ready=0, out_byte and out_last SHALL hold stable.
REQ-025 out_last SHALL be 1 only when index=59 and out_valid=1.
REQ-026 Acceptance at index 59 SHALL enter DONE. In DONE, enc_done=1 and out_valid=0 for one cycle, then the FSM returns to IDLE.
REQ-027 enc_busy SHALL be 1 in HDR, SALT and HASH, and 0 in IDLE and DONE.
REQ-028 enc_en SHALL be ignored in any state other than IDLE.
REQ-029 If cost < COST_MIN at capture, the FSM SHALL go directly to DONE: enc_done=1, err_cost=1, no characters emitted.
REQ-030 err_cost SHALL be 0 whenever enc_done=0.
REQ-031 Back-to-back operation SHALL be allowed: enc_en asserted in the IDLE cycle right after DONE is accepted.

Reset
REQ-032 When rst=0 at a clock edge, the block SHALL enter IDLE with index=0 and all outputs 0: enc_busy, enc_done, err_cost, out_valid, out_byte=8'h00, out_last.
REQ-033 Reset during HDR, SALT or HASH SHALL abort the stream. No enc_done is produced and no further characters follow.
REQ-034 rst=0 SHALL take priority over enc_en in the same cycle.

Verification
REQ-035 cost=10, salt=0, ctext=0, out_ready=1 -> "$2b$10$" then 53 '.' characters. out_last on the 60th. enc_done one cycle after the 60th.
REQ-036 cost=12, salt=all ones, ctext=all ones -> "$2b$12$", then 21 '9' + 'u', then 30 '9' + '6'.
REQ-037 cost=4 with out_ready low for 3 cycles at index 10 -> out_byte stable and the index frozen for those cycles. The full string is still correct, with "04" as the cost digits.
REQ-038 cost=3 -> enc_done=1 and err_cost=1 one cycle after capture. out_valid never asserts.
REQ-039 rst=0 at index 30 -> all outputs 0 next cycle. A following enc_en with cost=31 produces a fresh "$2b$31$..." string.
REQ-040 enc_en pulsed at index 20 with different inputs -> ignored. The in-flight string completes unchanged.

Source files
------------

// File: rtl/bcrypt_encode.sv
// bcrypt_encode: serialises a bcrypt hash string "$2b$DD$<salt22><hash31>"
// one ASCII character per accepted transfer on a valid/ready byte stream.
module bcrypt_encode #(
   parameter logic [7:0] VERSION_CHAR = 8'h62,
   parameter int         COST_MIN     = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         enc_en,
   input  logic [4:0]   cost,
   input  logic [127:0] salt,
   input  logic [183:0] ctext,
   output logic         enc_busy,
   output logic         enc_done,
   output logic         err_cost,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [7:0]   out_byte,
   output logic         out_last
);

   typedef enum logic [2:0] {IDLE, HDR, SALT, HASH, DONE} state_t;

   localparam logic [4:0] COST_MIN_L = 5'(COST_MIN);

   state_t         state, state_next;
   logic [5:0]     idx, idx_next;
   logic [131:0]   salt_sr;
   logic [185:0]   hash_sr;
   logic [4:0]     cost_q;
   logic           err_q;
   logic           accept;
   logic           cost_bad;
   logic [3:0]     tens, ones;

   // Maps a 6-bit group onto the bcrypt alphabet "./A-Za-z0-9".
   function automatic logic [7:0] encode6(input logic [5:0] g);
      logic [7:0] w;
      w = {2'b00, g};
      if (g < 6'd2)       encode6 = (g == 6'd0) ? 8'h2E : 8'h2F;
      else if (g < 6'd28) encode6 = w + 8'd63;
      else if (g < 6'd54) encode6 = w + 8'd69;
      else                encode6 = w - 8'd6;
   endfunction

   assign accept   = out_valid && out_ready;
   assign cost_bad = (cost < COST_MIN_L);

   // State and character index register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state <= IDLE;
         idx   <= 6'd0;
      end else begin
         state <= state_next;
         idx   <= idx_next;
      end
   end

   // Next-state logic: the index only moves on an accepted character.
   always_comb begin
      state_next = state;
      idx_next   = idx;
      case (state)
         IDLE: begin
            if (enc_en) begin
               idx_next   = 6'd0;
               state_next = cost_bad ? DONE : HDR;
            end
         end
         HDR: begin
            if (accept) begin
               idx_next = idx + 6'd1;
               if (idx == 6'd6) state_next = SALT;
            end
         end
         SALT: begin
            if (accept) begin
               idx_next = idx + 6'd1;
               if (idx == 6'd28) state_next = HASH;
            end
         end
         HASH: begin
            if (accept) begin
               if (idx == 6'd59) begin
                  idx_next   = 6'd0;
                  state_next = DONE;
               end else begin
                  idx_next = idx + 6'd1;
               end
            end
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Capture padded salt/ciphertext on start; shift out 6 bits per accepted payload character.
   always_ff @(posedge clk) begin
      if (!rst) begin
         salt_sr <= '0;
         hash_sr <= '0;
         cost_q  <= '0;
         err_q   <= 1'b0;
      end else if (state == IDLE && enc_en) begin
         salt_sr <= {salt, 4'b0000};
         hash_sr <= {ctext, 2'b00};
         cost_q  <= cost;
         err_q   <= cost_bad;
      end else begin
         if (state == SALT && accept) salt_sr <= salt_sr << 6;
         if (state == HASH && accept) hash_sr <= hash_sr << 6;
      end
   end

   // Split the captured cost into two decimal digits.
   always_comb begin
      tens = 4'd0;
      ones = cost_q[3:0];
      if (cost_q >= 5'd30) begin
         tens = 4'd3;
         ones = 4'(cost_q - 5'd30);
      end else if (cost_q >= 5'd20) begin
         tens = 4'd2;
         ones = 4'(cost_q - 5'd20);
      end else if (cost_q >= 5'd10) begin
         tens = 4'd1;
         ones = 4'(cost_q - 5'd10);
      end
   end

   // Output character selection; everything is zero outside the streaming states.
   always_comb begin
      out_byte = 8'h00;
      case (state)
         HDR: begin
            case (idx)
               6'd0:    out_byte = 8'h24;
               6'd1:    out_byte = 8'h32;
               6'd2:    out_byte = VERSION_CHAR;
               6'd3:    out_byte = 8'h24;
               6'd4:    out_byte = 8'h30 + {4'h0, tens};
               6'd5:    out_byte = 8'h30 + {4'h0, ones};
               6'd6:    out_byte = 8'h24;
               default: out_byte = 8'h00;
            endcase
         end
         SALT:    out_byte = encode6(salt_sr[131:126]);
         HASH:    out_byte = encode6(hash_sr[185:180]);
         default: out_byte = 8'h00;
      endcase
   end

   assign out_valid = (state == HDR) || (state == SALT) || (state == HASH);
   assign enc_busy  = out_valid;
   assign enc_done  = (state == DONE);
   assign err_cost  = (state == DONE) && err_q;
   assign out_last  = (state == HASH) && (idx == 6'd59);

endmodule
